barrel_dispatcher: RTL and testbench
====================================

BARREL_DISPATCHER -- requirements
Module: barrel_dispatcher

Interface
REQ-001 SHALL have parameter SPAWN_DELAY, default 50_000_000, meaning idle cycles between the end of one barrel and the next throw.
REQ-002 SHALL have parameter THROW_TIME, default 12_500_000, meaning cycles for which kong_throw is held before launch.
REQ-003 SHALL have port clk, input, 1 bit, system clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port game_en, input, 1 bit, level that enables throwing.
REQ-006 SHALL have port ver_done, input, 1 bit, done pulse from the vertical-barrel stage.
REQ-007 SHALL have port hor_done, input, 1 bit, done pulse from the horizontal-barrel stage.
REQ-008 SHALL have port barrel_hit, input, 1 bit, OR of the hit flags from both barrel stages.
REQ-009 SHALL have port ver_barrel, output, 1 bit, one-cycle start pulse to the vertical stage.
REQ-010 SHALL have port hor_barrel, output, 1 bit, one-cycle start pulse to the horizontal stage.
REQ-011 SHALL have port kong_throw, output, 1 bit, level that drives the kong throw animation.
REQ-012 SHALL have port barrels_thrown, output, 8 bits, count of launches this game.

Function
REQ-013 SHALL implement FSM states ST_IDLE, ST_WAIT, ST_THROW, ST_LAUNCH, ST_BUSY and ST_HALT; all outputs SHALL be registered.
REQ-014 ST_IDLE SHALL go to ST_WAIT when game_en=1 and clear the delay counter; otherwise it SHALL stay.
REQ-015 ST_WAIT SHALL count from 0 to SPAWN_DELAY-1 and then go to ST_THROW.
REQ-016 ST_THROW SHALL assert kong_throw for exactly THROW_TIME cycles and then go to ST_LAUNCH.
REQ-017 ST_LAUNCH SHALL last one cycle and SHALL pulse exactly one of ver_barrel or hor_barrel, chosen by the selector bit latched on entry to ST_THROW (1 = vertical).
REQ-018 ST_LAUNCH SHALL increment barrels_thrown, saturating at 255, and then go to ST_BUSY.
REQ-019 ST_BUSY SHALL wait for the done input of the selected type only.
  - The other done input SHALL be ignored.
  - On that done the FSM SHALL go to ST_WAIT.
REQ-020 If barrel_hit=1 in any state other than ST_IDLE, the next state SHALL be ST_HALT and kong_throw SHALL drop in the same edge; barrel_hit SHALL take priority over a simultaneous done.
REQ-021 ST_HALT SHALL stay until game_en=0, then go to ST_IDLE and clear barrels_thrown.
REQ-022 If game_en falls in ST_WAIT or ST_THROW, the FSM SHALL return to ST_IDLE without launching.
REQ-023 If game_en falls in ST_BUSY, the FSM SHALL finish waiting for done and then go to ST_IDLE.
REQ-024 Latency from the final kong_throw cycle to the start pulse SHALL be exactly 1 cycle.
REQ-025 At most one start pulse SHALL be issued per barrel; no start pulse SHALL be issued while in ST_BUSY.

Reset
REQ-026 On rst the FSM SHALL enter ST_IDLE.
REQ-027 On rst, ver_barrel, hor_barrel, kong_throw, barrels_thrown and all counters SHALL be 0.
REQ-028 On rst the selector state SHALL be reloaded to its seed.
REQ-029 rst mid-throw or mid-busy SHALL abort with no start pulse in the following cycle.

Configuration
REQ-030 With BARREL_RANDOM_EN defined:
  - the selector SHALL be a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1;
  - it SHALL advance every cycle;
  - the selected type SHALL be LFSR bit 0 at ST_THROW entry.
REQ-031 Without BARREL_RANDOM_EN, the selector SHALL alternate vertical/horizontal, starting with vertical after reset or after ST_HALT.

Structure
REQ-032 The FSM state typedef, LFSR seed and taps, and default timing constants SHALL live in barrel_pkg.
REQ-033 The LFSR SHALL be a separate sub-module, barrel_lfsr, instantiated only under BARREL_RANDOM_EN.

Verification
REQ-034 Bench SHALL use SPAWN_DELAY=10 and THROW_TIME=4 for all scenarios below.
REQ-035 Macro off, game_en=1 from cycle 0 → ST_THROW entered after 10 cycles, kong_throw high for 4 cycles, then ver_barrel pulses for 1 cycle and barrels_thrown=1.
REQ-036 Macro off, ver_done returned 20 cycles after the pulse → 10 idle cycles, then the next launch is hor_barrel and barrels_thrown=2.
REQ-037 hor_done pulsed while waiting on a vertical barrel → no state change; only ver_done releases ST_BUSY.
REQ-038 barrel_hit and ver_done asserted in the same cycle in ST_BUSY → ST_HALT, no further pulses; game_en=0 → ST_IDLE with barrels_thrown=0.
REQ-039 rst asserted in the 2nd kong_throw cycle → all outputs 0 on the next edge, no start pulse; 300 launches → barrels_thrown holds at 255.
REQ-040 Macro on, reset then 3 launches → the sequence of pulse types matches a reference LFSR model seeded 16'hACE1.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared types and constants for the barrel dispatcher: FSM states, timing defaults
// and the selector LFSR definition.
package barrel_pkg;

    localparam int unsigned SPAWN_DELAY_DEF = 50_000_000;
    localparam int unsigned THROW_TIME_DEF  = 12_500_000;
    localparam int unsigned CNT_W           = 32;
    localparam int unsigned THROWN_W        = 8;
    localparam int unsigned LFSR_W          = 16;

    // Taps 16,14,13,11 of the right-shifting Fibonacci form land on bits 0,2,3,5.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_THROW,
        ST_LAUNCH,
        ST_BUSY,
        ST_HALT
    } state_e;

endpackage

// File: rtl/barrel_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the random barrel-type selector.
module barrel_lfsr
    import barrel_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = {^(state_q & LFSR_TAPS), state_q[LFSR_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/barrel_dispatcher.sv
// Barrel dispatcher: paces kong throws and issues vertical/horizontal barrel launches.
// Define BARREL_RANDOM_EN to choose the barrel type from an LFSR instead of alternating.
module barrel_dispatcher
    import barrel_pkg::*;
#(
    parameter int unsigned SPAWN_DELAY = SPAWN_DELAY_DEF,
    parameter int unsigned THROW_TIME  = THROW_TIME_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                game_en,
    input  logic                ver_done,
    input  logic                hor_done,
    input  logic                barrel_hit,
    output logic                ver_barrel,
    output logic                hor_barrel,
    output logic                kong_throw,
    output logic [THROWN_W-1:0] barrels_thrown
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sel_q, sel_d;
    logic                kong_q, kong_d;
    logic                ver_q, ver_d;
    logic                hor_q, hor_d;
    logic [THROWN_W-1:0] thrown_q, thrown_d;
    logic                sel_src;

`ifdef BARREL_RANDOM_EN
    logic [LFSR_W-1:0] lfsr_state;

    barrel_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_state)
    );

    assign sel_src = lfsr_state[0];
`else
    logic alt_q, alt_d;

    // Alternate after every launch; a finished game restarts on vertical.
    always_comb begin
        alt_d = alt_q;
        if (state_q == ST_LAUNCH) begin
            alt_d = ~alt_q;
        end
        if (state_q == ST_HALT && state_d == ST_IDLE) begin
            alt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alt_q <= 1'b1;
        end else begin
            alt_q <= alt_d;
        end
    end

    assign sel_src = alt_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        kong_d   = 1'b0;
        ver_d    = 1'b0;
        hor_d    = 1'b0;
        thrown_d = thrown_q;

        unique case (state_q)
            ST_IDLE: begin
                if (game_en) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (!game_en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(SPAWN_DELAY - 1)) begin
                    state_d = ST_THROW;
                    cnt_d   = '0;
                    sel_d   = sel_src;
                    kong_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_THROW: begin
                if (!game_en) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(THROW_TIME - 1)) begin
                    state_d = ST_LAUNCH;
                    ver_d   = sel_q;
                    hor_d   = ~sel_q;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    kong_d = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_BUSY;
                if (thrown_q != '1) begin
                    thrown_d = thrown_q + THROWN_W'(1);
                end
            end
            ST_BUSY: begin
                if (sel_q ? ver_done : hor_done) begin
                    state_d = game_en ? ST_WAIT : ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_HALT: begin
                if (!game_en) begin
                    state_d  = ST_IDLE;
                    thrown_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A hit ends the game from anywhere in play and outranks a simultaneous done.
        if (barrel_hit && state_q != ST_IDLE) begin
            state_d = ST_HALT;
            kong_d  = 1'b0;
            ver_d   = 1'b0;
            hor_d   = 1'b0;
            if (state_q == ST_HALT) begin
                thrown_d = thrown_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            kong_q   <= 1'b0;
            ver_q    <= 1'b0;
            hor_q    <= 1'b0;
            thrown_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            kong_q   <= kong_d;
            ver_q    <= ver_d;
            hor_q    <= hor_d;
            thrown_q <= thrown_d;
        end
    end

    assign ver_barrel     = ver_q;
    assign hor_barrel     = hor_q;
    assign kong_throw     = kong_q;
    assign barrels_thrown = thrown_q;

endmodule

// File: tb/tb_barrel_dispatcher.sv
// Self-checking bench for barrel_dispatcher; honours BARREL_RANDOM_EN for the type model.
module tb_barrel_dispatcher;

    localparam int unsigned D = 10;
    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_en;
    logic       ver_done;
    logic       hor_done;
    logic       barrel_hit;
    logic       ver_barrel;
    logic       hor_barrel;
    logic       kong_throw;
    logic [7:0] barrels_thrown;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_thrown = 0;
    bit alt_ver  = 1'b1;

    barrel_dispatcher #(
        .SPAWN_DELAY (D),
        .THROW_TIME  (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .game_en        (game_en),
        .ver_done       (ver_done),
        .hor_done       (hor_done),
        .barrel_hit     (barrel_hit),
        .ver_barrel     (ver_barrel),
        .hor_barrel     (hor_barrel),
        .kong_throw     (kong_throw),
        .barrels_thrown (barrels_thrown)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

`ifdef BARREL_RANDOM_EN
    // Bit 0 of the reference LFSR after the given number of single-step advances from the seed.
    function automatic bit lfsr_type(input int advances);
        int s;
        int fb;
        s = 'hACE1;
        for (int i = 0; i < advances; i++) begin
            fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s  = (s >> 1) | (fb << 15);
        end
        return bit'(s & 1);
    endfunction
`endif

    // cyc counts rising edges taken with rst low since the last reset.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) cyc = 0;
        else     cyc++;
    endtask

    task automatic quiet(input string tag);
        check({tag, "_kong"}, 32'(kong_throw), 0);
        check({tag, "_pulse"}, 32'({ver_barrel, hor_barrel}), 0);
    endtask

    // Called right after the edge that starts the spawn wait.
    task automatic expect_launch(output bit typ);
`ifdef BARREL_RANDOM_EN
        typ = lfsr_type(cyc + int'(D) - 1);
`else
        typ = alt_ver;
`endif
        for (int i = 0; i < int'(D) - 1; i++) begin
            tick();
            quiet("wait");
        end
        for (int i = 0; i < int'(T); i++) begin
            tick();
            check("kong_hi", 32'(kong_throw), 1);
            check("throw_pulse", 32'({ver_barrel, hor_barrel}), 0);
        end
        tick();
        check("launch_ver", 32'(ver_barrel), 32'(typ));
        check("launch_hor", 32'(hor_barrel), 32'(!typ));
        check("launch_kong", 32'(kong_throw), 0);
        n_thrown++;
        alt_ver = !alt_ver;
        tick();
        quiet("post_launch");
        check("thrown", 32'(barrels_thrown), (n_thrown > 255) ? 255 : n_thrown);
    endtask

    // Called one cycle after the launch pulse; returns the done after lat cycles from the pulse.
    task automatic finish_busy(input int lat, input bit typ, input bit spurious);
        for (int i = 0; i < lat - 2; i++) begin
            if (spurious) begin
                if (typ) hor_done = (i == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
                else     ver_done = (i == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
            end
            tick();
            ver_done = 1'b0;
            hor_done = 1'b0;
            quiet("busy");
        end
        if (typ) ver_done = 1'b1;
        else     hor_done = 1'b1;
        tick();
        ver_done = 1'b0;
        hor_done = 1'b0;
    endtask

    initial begin
        bit typ;
        rst        = 1'b1;
        game_en    = 1'b0;
        ver_done   = 1'b0;
        hor_done   = 1'b0;
        barrel_hit = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            quiet("reset");
            check("reset_thrown", 32'(barrels_thrown), 0);
        end

        // Normal play: slow first done, a spurious other-type done, then random returns.
        rst     = 1'b0;
        game_en = 1'b1;
        tick();
        expect_launch(typ);
        finish_busy(20, typ, 1'b0);
        expect_launch(typ);
        finish_busy(12, typ, 1'b1);
        for (int b = 0; b < 4; b++) begin
            expect_launch(typ);
            finish_busy(int'($urandom_range(2, 25)), typ, 1'($urandom_range(0, 1)));
        end

        // Hit together with the awaited done: must halt, not resume.
        expect_launch(typ);
        barrel_hit = 1'b1;
        if (typ) ver_done = 1'b1;
        else     hor_done = 1'b1;
        tick();
        barrel_hit = 1'b0;
        ver_done   = 1'b0;
        hor_done   = 1'b0;
        quiet("halt");
        for (int i = 0; i < int'(D + T) + 3; i++) begin
            tick();
            quiet("halt_hold");
        end
        check("halt_thrown", 32'(barrels_thrown), n_thrown);
        game_en = 1'b0;
        tick();
        check("halt_clear", 32'(barrels_thrown), 0);
        n_thrown = 0;
        alt_ver  = 1'b1;

        // Enable drops during the spawn wait.
        game_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            quiet("wait_pre_abort");
        end
        game_en = 1'b0;
        for (int i = 0; i < int'(D + T) + 3; i++) begin
            tick();
            quiet("wait_abort");
        end
        check("wait_abort_thrown", 32'(barrels_thrown), 0);

        // Enable drops in the second throw cycle.
        game_en = 1'b1;
        tick();
        for (int i = 0; i < int'(D) - 1; i++) begin
            tick();
            quiet("wait2");
        end
        tick();
        check("throw1_kong", 32'(kong_throw), 1);
        tick();
        check("throw2_kong", 32'(kong_throw), 1);
        game_en = 1'b0;
        for (int i = 0; i < int'(D + T) + 3; i++) begin
            tick();
            quiet("throw_abort");
        end
        check("throw_abort_thrown", 32'(barrels_thrown), 0);

        // Enable drops while busy: wait for the done, then idle.
        game_en = 1'b1;
        tick();
        expect_launch(typ);
        game_en = 1'b0;
        finish_busy(5, typ, 1'b1);
        for (int i = 0; i < int'(D + T) + 3; i++) begin
            tick();
            quiet("busy_abort");
        end
        check("busy_abort_thrown", 32'(barrels_thrown), n_thrown);

        // Reset in the second throw cycle.
        game_en = 1'b1;
        tick();
        for (int i = 0; i < int'(D) - 1; i++) begin
            tick();
            quiet("wait3");
        end
        tick();
        tick();
        check("rst_throw2_kong", 32'(kong_throw), 1);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            quiet("rst_abort");
            check("rst_abort_thrown", 32'(barrels_thrown), 0);
        end
        rst      = 1'b0;
        n_thrown = 0;
        alt_ver  = 1'b1;
        tick();

        // Saturation: 300 back-to-back barrels.
        for (int b = 0; b < 300; b++) begin
            expect_launch(typ);
            finish_busy(2, typ, 1'b0);
        end
        check("sat_final", 32'(barrels_thrown), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
